// File: rtl/wish_master_fsm_if.sv
// Host request/response and Wishbone master bus bundle for wish_master_fsm.
// The master modport is the FSM; the slave modport is the host plus the Wishbone slave.
interface wish_master_fsm_if #(
  parameter int unsigned ADDRESS_LENGTH = 32,
  parameter int unsigned DATA_LENGTH    = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [ADDRESS_LENGTH-1:0] req_adr;
  logic [DATA_LENGTH-1:0]    req_dat;
  logic [ADDRESS_LENGTH-1:0] ADR_O;
  logic [DATA_LENGTH-1:0]    DAT_O;
  logic [DATA_LENGTH-1:0]    DAT_I;
  logic                      we;
  logic                      stb;
  logic                      cyc;
  logic                      ack;
  logic                      rsp_valid;
  logic [DATA_LENGTH-1:0]    rsp_dat;
  logic                      rsp_err;

  modport master (
    input  req_valid, req_we, req_adr, req_dat, DAT_I, ack,
    output req_ready, ADR_O, DAT_O, we, stb, cyc, rsp_valid, rsp_dat, rsp_err
  );

  modport slave (
    output req_valid, req_we, req_adr, req_dat, DAT_I, ack,
    input  req_ready, ADR_O, DAT_O, we, stb, cyc, rsp_valid, rsp_dat, rsp_err
  );
endinterface

// File: rtl/wish_master_fsm.sv
// Single-transaction Wishbone master: accepts one host request, runs one bus
// cycle with an ack timeout, and reports completion with a one-cycle pulse.
module wish_master_fsm #(
  parameter int unsigned ADDRESS_LENGTH = 32,
  parameter int unsigned DATA_LENGTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  wish_master_fsm_if.master bus
);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RESP     = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDRESS_LENGTH-1:0] adr_q, adr_d;
  logic [DATA_LENGTH-1:0]    dat_q, dat_d;
  logic [DATA_LENGTH-1:0]    rsp_dat_q, rsp_dat_d;
  logic                      we_q, we_d;
  logic                      cyc_q, cyc_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q, rsp_err_d;

  // State and registered outputs; reset aborts any bus cycle without a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next state and next output values; ack outranks a timeout on the same edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          adr_d   = bus.req_adr;
          dat_d   = bus.req_dat;
          we_d    = bus.req_we;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.ack) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : bus.DAT_I;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.ADR_O     = adr_q;
  assign bus.DAT_O     = dat_q;
  assign bus.we        = we_q;
  assign bus.cyc       = cyc_q;
  assign bus.stb       = cyc_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_wish_master_fsm.sv
// Randomized scoreboard bench for wish_master_fsm: the driver predicts each
// completion from the ack timing it chooses; a negedge monitor checks the bus.
module tb_wish_master_fsm;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned T  = 4;

  typedef struct {
    logic [DW-1:0] dat;
    logic          err;
    int            cycles;
  } exp_t;

  logic clk;
  logic rst_n;

  wish_master_fsm_if #(.ADDRESS_LENGTH(AW), .DATA_LENGTH(DW)) bus ();

  wish_master_fsm #(
    .ADDRESS_LENGTH(AW),
    .DATA_LENGTH   (DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int            tests = 0;
  int            fails = 0;
  exp_t          exp_q[$];
  exp_t          mon_e;
  bit            in_txn;
  bit            busy;
  logic [AW-1:0] cur_adr;
  logic [DW-1:0] cur_dat;
  logic          cur_we;
  logic [DW-1:0] last_dat;
  logic          last_err;
  int            cyc_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected bus view derived from what the driver has issued.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_dat = '0;
      last_err = 1'b0;
      cyc_cnt  = 0;
    end else begin
      check("cyc", 64'(bus.cyc), 64'(in_txn));
      check("stb", 64'(bus.stb), 64'(in_txn));
      check("we", 64'(bus.we), 64'(in_txn ? cur_we : 1'b0));
      check("adr_o", 64'(bus.ADR_O), 64'(cur_adr));
      check("dat_o", 64'(bus.DAT_O), 64'(cur_dat));
      check("req_ready", 64'(bus.req_ready), 64'(!busy));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(busy && !in_txn));
      if (bus.cyc) cyc_cnt++;
      if (bus.rsp_valid) begin
        check("sb_pending", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("rsp_dat", 64'(bus.rsp_dat), 64'(mon_e.dat));
          check("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
          check("cyc_len", 64'(cyc_cnt), 64'(mon_e.cycles));
          last_dat = mon_e.dat;
          last_err = mon_e.err;
        end
        cyc_cnt = 0;
      end else begin
        check("rsp_dat_hold", 64'(bus.rsp_dat), 64'(last_dat));
        check("rsp_err_hold", 64'(bus.rsp_err), 64'(last_err));
      end
    end
  end

  // One request; the slave acks on WAIT_ACK edge k, or never when k > T.
  task automatic run_txn(input bit we_i, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input int k, input logic [DW-1:0] rdata, input bit keep_valid);
    exp_t e;
    e.err    = (k > int'(T));
    e.dat    = (e.err || we_i) ? '0 : rdata;
    e.cycles = e.err ? int'(T) : k;
    exp_q.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_we    = we_i;
    bus.req_adr   = adr;
    bus.req_dat   = dat;
    @(posedge clk); #1;
    in_txn  = 1'b1;
    busy    = 1'b1;
    cur_adr = adr;
    cur_dat = dat;
    cur_we  = we_i;
    if (keep_valid) begin
      bus.req_we  = 1'($urandom_range(0, 1));
      bus.req_adr = $urandom;
      bus.req_dat = $urandom;
    end else begin
      bus.req_valid = 1'b0;
    end
    for (int i = 1; i <= int'(T); i++) begin
      bus.ack   = (i == k);
      bus.DAT_I = (i == k) ? rdata : $urandom;
      @(posedge clk); #1;
      if (i == k) break;
    end
    bus.ack       = 1'b0;
    bus.req_valid = 1'b0;
    in_txn        = 1'b0;
    @(posedge clk); #1;
    busy = 1'b0;
  endtask

  task automatic idle(input int g, input bit spur);
    for (int i = 0; i < g; i++) begin
      bus.ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.DAT_I = $urandom;
      @(posedge clk); #1;
    end
    bus.ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_adr   = '0;
    bus.req_dat   = '0;
    bus.DAT_I     = '0;
    bus.ack       = 1'b0;
    in_txn        = 1'b0;
    busy          = 1'b0;
    cur_adr       = '0;
    cur_dat       = '0;
    cur_we        = 1'b0;
    #2;
    check("rst_cyc", 64'(bus.cyc), 64'(0));
    check("rst_stb", 64'(bus.stb), 64'(0));
    check("rst_adr", 64'(bus.ADR_O), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_req_ready", 64'(bus.req_ready), 64'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 2, 32'h0BADF00D, 1'b0);
    idle(1, 1'b0);
    run_txn(1'b0, 32'h10, 32'h12345678, 1, 32'hDEADBEEF, 1'b0);
    run_txn(1'b0, 32'h44, 32'h0, 99, 32'h11111111, 1'b0);
    idle(2, 1'b0);
    run_txn(1'b0, 32'h48, 32'h0, 4, 32'h5A5A5A5A, 1'b0);
    idle(3, 1'b1);
    run_txn(1'b1, 32'h80, 32'hCAFEF00D, 3, 32'h77, 1'b1);
    idle(2, 1'b1);

    // Abort a bus cycle with an asynchronous reset between clock edges.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_adr   = 32'h90;
    bus.req_dat   = 32'h13579BDF;
    @(posedge clk); #1;
    in_txn  = 1'b1;
    busy    = 1'b1;
    cur_adr = 32'h90;
    cur_dat = 32'h13579BDF;
    cur_we  = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n   = 1'b0;
    in_txn  = 1'b0;
    busy    = 1'b0;
    cur_adr = '0;
    cur_dat = '0;
    cur_we  = 1'b0;
    #1;
    check("arst_cyc", 64'(bus.cyc), 64'(0));
    check("arst_stb", 64'(bus.stb), 64'(0));
    check("arst_we", 64'(bus.we), 64'(0));
    check("arst_adr", 64'(bus.ADR_O), 64'(0));
    check("arst_dat", 64'(bus.DAT_O), 64'(0));
    check("arst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("arst_rsp_dat", 64'(bus.rsp_dat), 64'(0));
    check("arst_req_ready", 64'(bus.req_ready), 64'(1));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run_txn(1'b0, 32'h20, 32'h0, 2, 32'hA5A50001, 1'b0);

    for (int n = 0; n < 60; n++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(1, T + 2)),
              $urandom, 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
